// File: rtl/ftq_ctrl.sv
// Fetch Target Queue controller: buffers BPU fetch blocks in a circular queue,
// issues them in order to the icache, retires them on commit and emits FTB updates.
module ftq_ctrl #(
  parameter int XLEN       = 64,
  parameter int FTQ_SIZE   = 8,
  parameter int PRED_WIDTH = 16,
  localparam int IDXW      = $clog2(FTQ_SIZE),
  localparam int PTRW      = IDXW + 1,
  localparam int SZW       = $clog2(PRED_WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_bp_vld,
  output logic            o_bp_rdy,
  input  logic [XLEN-1:0] i_bp_start,
  input  logic [XLEN-1:0] i_bp_end,
  input  logic            i_bp_taken,
  input  logic [XLEN-1:0] i_bp_target,
  input  logic            i_bp_hit,
  input  logic [1:0]      i_bp_cnt,
  output logic            o_ic_vld,
  input  logic            i_ic_rdy,
  output logic [XLEN-1:0] o_ic_start,
  output logic [SZW-1:0]  o_ic_size,
  output logic [PTRW-1:0] o_ic_ftq_idx,
  input  logic            i_cmt_vld,
  input  logic            i_cmt_taken,
  input  logic            i_sq_vld,
  input  logic [PTRW-1:0] i_sq_ptr,
  output logic            o_upd_vld,
  output logic [XLEN-1:0] o_upd_start,
  output logic [1:0]      o_upd_cnt,
  output logic            o_upd_taken,
  output logic            o_upd_newentry
);

  localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and squash overrides both enqueue and fetch.

  logic [PTRW-1:0] r_enq;
  logic [PTRW-1:0] r_fch;
  logic [PTRW-1:0] r_cmt;

  logic [XLEN-1:0] r_start [FTQ_SIZE];
  logic [SZW-1:0]  r_size  [FTQ_SIZE];
  logic            r_hit   [FTQ_SIZE];
  logic [1:0]      r_cnt   [FTQ_SIZE];

  logic [IDXW-1:0] w_enq_idx;
  logic [IDXW-1:0] w_fch_idx;
  logic [IDXW-1:0] w_cmt_idx;
  logic            w_full;
  logic            w_enq_fire;
  logic            w_fch_fire;
  logic [XLEN-1:0] w_diff;
  logic [SZW-1:0]  w_size;
  logic [1:0]      w_cur_cnt;
  logic [1:0]      w_new_cnt;
  logic            w_unused;

  assign w_enq_idx = r_enq[IDXW-1:0];
  assign w_fch_idx = r_fch[IDXW-1:0];
  assign w_cmt_idx = r_cmt[IDXW-1:0];

  assign w_full     = (w_enq_idx == w_cmt_idx) && (r_enq[PTRW-1] != r_cmt[PTRW-1]);
  assign o_bp_rdy   = !w_full;
  assign w_enq_fire = i_bp_vld && !w_full && !i_sq_vld;

  assign o_ic_vld     = (r_fch != r_enq) && !i_sq_vld;
  assign w_fch_fire   = o_ic_vld && i_ic_rdy;
  assign o_ic_start   = r_start[w_fch_idx];
  assign o_ic_size    = r_size[w_fch_idx];
  assign o_ic_ftq_idx = r_fch;

  // Fetch size is stored in half-words so the subtraction stays off the fetch path.
  assign w_diff = i_bp_end - i_bp_start;
  assign w_size = w_diff[SZW:1];

  // Direction and target are resolved by the backend; the queue does not need them.
  assign w_unused = ^{i_bp_taken, i_bp_target, w_diff[XLEN-1:SZW+1], w_diff[0]};

  assign w_cur_cnt = r_cnt[w_cmt_idx];

  always_comb begin
    w_new_cnt = w_cur_cnt;
    if (i_cmt_taken) begin
      if (w_cur_cnt != 2'd3) w_new_cnt = w_cur_cnt + 2'd1;
    end else begin
      if (w_cur_cnt != 2'd0) w_new_cnt = w_cur_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_start[w_enq_idx] <= i_bp_start;
      r_size[w_enq_idx]  <= w_size;
      r_hit[w_enq_idx]   <= i_bp_hit;
      r_cnt[w_enq_idx]   <= i_bp_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enq <= '0;
      r_fch <= '0;
      r_cmt <= '0;
    end else begin
      if (i_sq_vld) begin
        r_enq <= i_sq_ptr + PTR_ONE;
        r_fch <= i_sq_ptr + PTR_ONE;
      end else begin
        if (w_enq_fire) r_enq <= r_enq + PTR_ONE;
        if (w_fch_fire) r_fch <= r_fch + PTR_ONE;
      end
      if (i_cmt_vld) r_cmt <= r_cmt + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_upd_vld      <= 1'b0;
      o_upd_start    <= '0;
      o_upd_cnt      <= 2'd0;
      o_upd_taken    <= 1'b0;
      o_upd_newentry <= 1'b0;
    end else begin
      o_upd_vld <= i_cmt_vld;
      if (i_cmt_vld) begin
        o_upd_start    <= r_start[w_cmt_idx];
        o_upd_cnt      <= w_new_cnt;
        o_upd_taken    <= i_cmt_taken;
        o_upd_newentry <= !r_hit[w_cmt_idx];
      end
    end
  end

  // Retiring a block that was never fetched would break cmt <= fch.
  always_ff @(posedge clk) begin
    if (!rst && i_cmt_vld) assert (r_cmt != r_fch);
  end

endmodule

// File: tb/tb_ftq_ctrl.sv
// Directed bench for ftq_ctrl: reset, fill/full, counter updates, squash
// rollback, squash collisions and a 20-round wrap run with expected queues.
module tb_ftq_ctrl;

  logic        clk;
  logic        rst;
  logic        i_bp_vld;
  logic        o_bp_rdy;
  logic [63:0] i_bp_start;
  logic [63:0] i_bp_end;
  logic        i_bp_taken;
  logic [63:0] i_bp_target;
  logic        i_bp_hit;
  logic [1:0]  i_bp_cnt;
  logic        o_ic_vld;
  logic        i_ic_rdy;
  logic [63:0] o_ic_start;
  logic [3:0]  o_ic_size;
  logic [3:0]  o_ic_ftq_idx;
  logic        i_cmt_vld;
  logic        i_cmt_taken;
  logic        i_sq_vld;
  logic [3:0]  i_sq_ptr;
  logic        o_upd_vld;
  logic [63:0] o_upd_start;
  logic [1:0]  o_upd_cnt;
  logic        o_upd_taken;
  logic        o_upd_newentry;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_u[$];

  ftq_ctrl dut (
    .clk(clk), .rst(rst),
    .i_bp_vld(i_bp_vld), .o_bp_rdy(o_bp_rdy),
    .i_bp_start(i_bp_start), .i_bp_end(i_bp_end),
    .i_bp_taken(i_bp_taken), .i_bp_target(i_bp_target),
    .i_bp_hit(i_bp_hit), .i_bp_cnt(i_bp_cnt),
    .o_ic_vld(o_ic_vld), .i_ic_rdy(i_ic_rdy),
    .o_ic_start(o_ic_start), .o_ic_size(o_ic_size), .o_ic_ftq_idx(o_ic_ftq_idx),
    .i_cmt_vld(i_cmt_vld), .i_cmt_taken(i_cmt_taken),
    .i_sq_vld(i_sq_vld), .i_sq_ptr(i_sq_ptr),
    .o_upd_vld(o_upd_vld), .o_upd_start(o_upd_start), .o_upd_cnt(o_upd_cnt),
    .o_upd_taken(o_upd_taken), .o_upd_newentry(o_upd_newentry)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic offer(input logic [63:0] s, input logic [63:0] e,
                       input logic h, input logic [1:0] c);
    i_bp_vld   = 1'b1;
    i_bp_start = s;
    i_bp_end   = e;
    i_bp_hit   = h;
    i_bp_cnt   = c;
    i_bp_taken = 1'b1;
    i_bp_target = s + 64'h100;
    tick();
    i_bp_vld = 1'b0;
  endtask

  task automatic fetch_one();
    i_ic_rdy = 1'b1;
    tick();
    i_ic_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  logic [63:0] t2_start [8];
  logic        t2_hit   [8];
  logic [1:0]  t2_cnt   [8];

  initial begin
    logic [63:0] s;
    logic [1:0]  c;
    logic        h;
    logic [3:0]  p;
    rst = 1'b1;
    i_bp_vld = 0; i_bp_start = 0; i_bp_end = 0; i_bp_taken = 0; i_bp_target = 0;
    i_bp_hit = 0; i_bp_cnt = 0; i_ic_rdy = 0; i_cmt_vld = 0; i_cmt_taken = 0;
    i_sq_vld = 0; i_sq_ptr = 0;
    tick();
    tick();
    chk("rst_bp_rdy", o_bp_rdy, 1);
    chk("rst_ic_vld", o_ic_vld, 0);
    chk("rst_upd_vld", o_upd_vld, 0);
    chk("rst_upd_start", o_upd_start, 0);
    chk("rst_upd_cnt", o_upd_cnt, 0);
    rst = 1'b0;
    tick();

    // T1: single block, fetch, commit
    offer(64'h1000, 64'h1010, 1'b1, 2'd0);
    chk("t1_ic_vld", o_ic_vld, 1);
    chk("t1_ic_start", o_ic_start, 64'h1000);
    chk("t1_ic_size", o_ic_size, 8);
    chk("t1_ic_idx", o_ic_ftq_idx, 0);
    fetch_one();
    chk("t1_ic_vld_empty", o_ic_vld, 0);
    i_cmt_vld = 1; i_cmt_taken = 1;
    tick();
    i_cmt_vld = 0;
    chk("t1_upd_vld", o_upd_vld, 1);
    chk("t1_upd_start", o_upd_start, 64'h1000);
    chk("t1_upd_cnt", o_upd_cnt, 1);
    chk("t1_upd_taken", o_upd_taken, 1);
    chk("t1_upd_newentry", o_upd_newentry, 0);
    tick();
    chk("t1_upd_pulse", o_upd_vld, 0);

    // T2: fill from reset, full, ninth offer ignored
    do_reset();
    for (int i = 0; i < 8; i++) begin
      t2_start[i] = 64'h2000 + 64'(i) * 64'h10;
      t2_hit[i]   = (i != 2);
      t2_cnt[i]   = (i == 0) ? 2'd3 : (i == 1) ? 2'd0 : (i == 2) ? 2'd1 : 2'd2;
    end
    for (int i = 0; i < 8; i++) begin
      chk("t2_rdy_before", o_bp_rdy, 1);
      offer(t2_start[i], t2_start[i] + 64'h10, t2_hit[i], t2_cnt[i]);
    end
    chk("t2_rdy_full", o_bp_rdy, 0);
    i_bp_vld = 1; i_bp_start = 64'hdead; i_bp_end = 64'hdeae;
    tick();
    chk("t2_enq_ptr", dut.r_enq, 8);
    chk("t2_rdy_still_full", o_bp_rdy, 0);

    // T3: fetch three, then commit them with counter updates
    i_ic_rdy = 1;
    #1;
    chk("t3_f0_idx", o_ic_ftq_idx, 0);
    chk("t3_f0_start", o_ic_start, 64'h2000);
    tick();
    chk("t3_f1_idx", o_ic_ftq_idx, 1);
    tick();
    chk("t3_f2_start", o_ic_start, 64'h2020);
    tick();
    i_ic_rdy = 0;
    i_cmt_vld = 1; i_cmt_taken = 1;
    #1;
    chk("t3_rdy_during_cmt", o_bp_rdy, 0);
    tick();
    i_bp_vld = 0;
    chk("t3_c0_vld", o_upd_vld, 1);
    chk("t3_c0_start", o_upd_start, 64'h2000);
    chk("t3_c0_cnt", o_upd_cnt, 3);
    chk("t3_enq_unchanged", dut.r_enq, 8);
    chk("t3_rdy_after_cmt", o_bp_rdy, 1);
    i_cmt_taken = 0;
    tick();
    chk("t3_c1_start", o_upd_start, 64'h2010);
    chk("t3_c1_cnt", o_upd_cnt, 0);
    chk("t3_c1_taken", o_upd_taken, 0);
    i_cmt_taken = 1;
    tick();
    i_cmt_vld = 0;
    chk("t3_c2_cnt", o_upd_cnt, 2);
    chk("t3_c2_newentry", o_upd_newentry, 1);
    tick();
    chk("t3_upd_pulse", o_upd_vld, 0);

    // mid-operation reset discards pending entries at once
    chk("mr_ic_vld_before", o_ic_vld, 1);
    rst = 1'b1;
    #1;
    chk("mr_ic_vld", o_ic_vld, 0);
    chk("mr_bp_rdy", o_bp_rdy, 1);
    tick();
    rst = 1'b0;
    tick();

    // T4: enqueue 5, fetch 4, squash to ptr 1
    for (int i = 0; i < 5; i++)
      offer(64'h3000 + 64'(i) * 64'h10, 64'h3010 + 64'(i) * 64'h10, 1'b1, 2'd2);
    for (int i = 0; i < 4; i++) fetch_one();
    i_sq_vld = 1; i_sq_ptr = 4'd1;
    #1;
    chk("t4_ic_vld_sq", o_ic_vld, 0);
    tick();
    i_sq_vld = 0;
    chk("t4_enq_ptr", dut.r_enq, 2);
    chk("t4_fch_ptr", o_ic_ftq_idx, 2);
    chk("t4_ic_vld_empty", o_ic_vld, 0);
    offer(64'h4000, 64'h4010, 1'b0, 2'd1);
    chk("t4_new_vld", o_ic_vld, 1);
    chk("t4_new_start", o_ic_start, 64'h4000);
    chk("t4_new_idx", o_ic_ftq_idx, 2);
    i_cmt_vld = 1; i_cmt_taken = 0;
    tick();
    chk("t4_c0_start", o_upd_start, 64'h3000);
    chk("t4_c0_cnt", o_upd_cnt, 1);
    i_cmt_taken = 1;
    tick();
    i_cmt_vld = 0;
    chk("t4_c1_start", o_upd_start, 64'h3010);
    chk("t4_c1_cnt", o_upd_cnt, 3);
    fetch_one();

    // T5: squash colliding with enqueue and fetch handshake
    offer(64'h5000, 64'h5010, 1'b1, 2'd3);
    i_sq_vld = 1; i_sq_ptr = 4'd3;
    i_bp_vld = 1; i_bp_start = 64'h6000; i_bp_end = 64'h6010;
    i_ic_rdy = 1;
    #1;
    chk("t5_ic_vld_sq", o_ic_vld, 0);
    tick();
    i_sq_vld = 0; i_bp_vld = 0; i_ic_rdy = 0;
    chk("t5_enq_ptr", dut.r_enq, 4);
    chk("t5_fch_ptr", o_ic_ftq_idx, 4);
    chk("t5_ic_vld", o_ic_vld, 0);
    i_cmt_vld = 1; i_cmt_taken = 1;
    tick();
    chk("t5_c0_start", o_upd_start, 64'h4000);
    chk("t5_c0_cnt", o_upd_cnt, 2);
    chk("t5_c0_newentry", o_upd_newentry, 1);
    i_cmt_taken = 0;
    tick();
    i_cmt_vld = 0;
    chk("t5_c1_start", o_upd_start, 64'h5000);
    chk("t5_c1_cnt", o_upd_cnt, 2);
    chk("t5_c1_newentry", o_upd_newentry, 0);

    // T6: 20 rounds through pointer wrap, starting from pointer 4
    for (int i = 0; i < 20; i++) begin
      s = 64'h8000 + 64'(i) * 64'h40;
      h = (i % 3) != 0;
      c = 2'(i % 4);
      p = 4'(4 + i);
      exp_q.push_back(s);
      exp_u.push_back({s[60:0], h, c});
      offer(s, s + 64'(2 * ((i % 8) + 1)), h, c);
      chk("t6_ic_vld", o_ic_vld, 1);
      chk("t6_ic_start", o_ic_start, exp_q.pop_front());
      chk("t6_ic_size", o_ic_size, 64'((i % 8) + 1));
      chk("t6_ic_idx", o_ic_ftq_idx, p);
      fetch_one();
      i_cmt_vld = 1; i_cmt_taken = 1'(i % 2);
      tick();
      i_cmt_vld = 0;
      s = exp_u.pop_front();
      chk("t6_upd_vld", o_upd_vld, 1);
      chk("t6_upd_start", o_upd_start, {3'b000, s[63:3]});
      chk("t6_upd_newentry", o_upd_newentry, !s[2]);
      chk("t6_upd_cnt", o_upd_cnt, sat(s[1:0], 1'(i % 2)));
    end
    tick();
    chk("t6_upd_pulse", o_upd_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
